// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver with a valid/ready byte output.
// The input passes through a 2-flop synchronizer. Each bit is sampled at its
// midpoint by a wait counter. If the consumer has not taken the previous byte
// when a new one completes, the new byte is dropped and overrun_o pulses.
module uart_rx #(
  parameter int CLK_FREQ_MHZ = 100,
  parameter int BAUD_RATE    = 921600
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       rxd_i,
  output logic       rvalid_o,
  input  logic       rready_i,
  output logic [7:0] rdata_o,
  output logic       frame_err_o,
  output logic       overrun_o
);

  localparam int WAIT_COUNT = (CLK_FREQ_MHZ * 1000000) / BAUD_RATE;
  localparam int HALF       = WAIT_COUNT / 2;
  localparam int CW         = $clog2(WAIT_COUNT);

  localparam logic [CW-1:0] WAIT_LOAD = CW'(WAIT_COUNT - 1);
  localparam logic [CW-1:0] HALF_LOAD = CW'(HALF - 1);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] START = 3'd1;
  localparam logic [2:0] DATA  = 3'd2;
  localparam logic [2:0] STOP  = 3'd3;
  localparam logic [2:0] BREAK = 3'd4;

  logic          rx_meta, rx;
  logic [2:0]    state;
  logic [CW-1:0] wait_cnt;
  logic [2:0]    bit_cnt;
  logic [7:0]    shift;
  logic          evt;
  logic          stop_ok;
  logic          stop_bad;

  assign evt      = (wait_cnt == '0);
  assign stop_ok  = (state == STOP) && evt && rx;
  assign stop_bad = (state == STOP) && evt && !rx;

  // Two-flop synchronizer. Both flops reset to the idle-high line level.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rx_meta <= 1'b1;
      rx      <= 1'b1;
    end else begin
      rx_meta <= rxd_i;
      rx      <= rx_meta;
    end
  end

  // Frame FSM: start detection, mid-bit sampling, stop check, break wait.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state    <= IDLE;
      wait_cnt <= '0;
      bit_cnt  <= '0;
      shift    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (!rx) begin
            state    <= START;
            wait_cnt <= HALF_LOAD;
          end
        end
        START: begin
          if (evt) begin
            if (!rx) begin
              state    <= DATA;
              wait_cnt <= WAIT_LOAD;
              bit_cnt  <= 3'd7;
            end else begin
              // A low pulse that is gone by mid-start-bit is only a glitch.
              state <= IDLE;
            end
          end else begin
            wait_cnt <= wait_cnt - CW'(1);
          end
        end
        DATA: begin
          if (evt) begin
            shift    <= {rx, shift[7:1]};
            wait_cnt <= WAIT_LOAD;
            if (bit_cnt == 3'd0) state <= STOP;
            else                 bit_cnt <= bit_cnt - 3'd1;
          end else begin
            wait_cnt <= wait_cnt - CW'(1);
          end
        end
        STOP: begin
          wait_cnt <= wait_cnt - CW'(1);
          // Going idle at mid-stop-bit lets a back-to-back start bit be detected.
          if (evt) state <= rx ? IDLE : BREAK;
        end
        BREAK: begin
          wait_cnt <= wait_cnt - CW'(1);
          if (rx) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Output handshake plus the one-cycle frame-error and overrun pulses.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rvalid_o    <= 1'b0;
      rdata_o     <= 8'h00;
      frame_err_o <= 1'b0;
      overrun_o   <= 1'b0;
    end else begin
      frame_err_o <= stop_bad;
      overrun_o   <= 1'b0;
      if (stop_ok) begin
        if (!rvalid_o || rready_i) begin
          rdata_o  <= shift;
          rvalid_o <= 1'b1;
        end else begin
          overrun_o <= 1'b1;
        end
      end else if (rvalid_o && rready_i) begin
        rvalid_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: drives 8N1 frames on rxd_i and checks the received bytes and
// pulses against a queue-based model of what should arrive.
module tb_uart_rx;

  localparam int CLK_MHZ = 100;
  localparam int BAUD    = 921600;
  localparam int WC      = (CLK_MHZ * 1000000) / BAUD;
  localparam int HF      = WC / 2;
  // Clock edges from the line falling edge to the stop-bit sample:
  // 2 synchronizer flops, 1 IDLE detect, half a bit, then 9 full bits.
  localparam int LAT_EVT = 3 + HF + 9 * WC;

  logic       clk;
  logic       rst_n;
  logic       rxd;
  logic       rready;
  logic       rvalid;
  logic [7:0] rdata;
  logic       frame_err;
  logic       overrun;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int n_rise = 0, n_ferr = 0, n_ovr = 0, n_low = 0, rise_cyc = 0;
  bit prev_v = 1'b0;
  logic [7:0] got_q[$];
  logic [7:0] exp_q[$];

  uart_rx #(.CLK_FREQ_MHZ(CLK_MHZ), .BAUD_RATE(BAUD)) dut (
    .clk_i(clk), .rst_ni(rst_n), .rxd_i(rxd), .rvalid_o(rvalid),
    .rready_i(rready), .rdata_o(rdata), .frame_err_o(frame_err),
    .overrun_o(overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Observe outputs on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (rvalid && !prev_v) begin
      n_rise++;
      rise_cyc = cyc;
    end
    prev_v = rvalid;
    if (frame_err) n_ferr++;
    if (overrun)   n_ovr++;
    if (!rvalid)   n_low++;
    if (rvalid && rready) got_q.push_back(rdata);
  end

  task automatic drive_bit(input logic v);
    rxd = v;
    repeat (WC) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    drive_bit(stop);
  endtask

  task automatic test_reset;
    rst_n = 1'b0; rxd = 1'b1; rready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (rvalid !== 1'b0)    begin errors++; $display("FAIL reset_rvalid: got %b exp 0", rvalid); end
    checks++; if (rdata !== 8'h00)    begin errors++; $display("FAIL reset_rdata: got %h exp 00", rdata); end
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_ferr: got %b exp 0", frame_err); end
    checks++; if (overrun !== 1'b0)   begin errors++; $display("FAIL reset_ovr: got %b exp 0", overrun); end
    rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    checks++; if (rvalid !== 1'b0) begin errors++; $display("FAIL post_reset_rvalid: got %b exp 0", rvalid); end
  endtask

  task automatic test_basic;
    logic [7:0] b, g;
    int s, r0, f0, o0;
    rready = 1'b1;
    f0 = n_ferr; o0 = n_ovr;
    for (int k = 0; k < 5; k++) begin
      b = (k == 0) ? 8'hA5 : 8'($urandom_range(0, 255));
      exp_q.push_back(b);
      s = cyc; r0 = n_rise;
      send_frame(b, 1'b1);
      repeat (20) @(posedge clk);
      #1;
      checks++; if (n_rise != r0 + 1) begin errors++; $display("FAIL basic_rise: got %0d exp %0d", n_rise - r0, 1); end
      checks++;
      if (rise_cyc - s < LAT_EVT - 1 || rise_cyc - s > LAT_EVT + 3) begin
        errors++; $display("FAIL basic_latency: got %0d exp about %0d", rise_cyc - s, LAT_EVT + 1);
      end
      g = (got_q.size() != 0) ? got_q.pop_front() : 8'hxx;
      b = exp_q.pop_front();
      checks++; if (g !== b) begin errors++; $display("FAIL basic_data: got %h exp %h", g, b); end
    end
    checks++; if (n_ferr != f0 || n_ovr != o0) begin errors++; $display("FAIL basic_pulses: got ferr %0d ovr %0d exp 0 0", n_ferr - f0, n_ovr - o0); end
  endtask

  task automatic test_glitch;
    int r0, f0, o0, len;
    logic [7:0] g;
    rready = 1'b1;
    r0 = n_rise; f0 = n_ferr; o0 = n_ovr;
    for (int k = 0; k < 2; k++) begin
      len = (k == 0) ? 20 : $urandom_range(5, 40);
      rxd = 1'b0;
      repeat (len) @(posedge clk);
      #1 rxd = 1'b1;
      repeat (200) @(posedge clk);
      #1;
    end
    checks++; if (n_rise != r0) begin errors++; $display("FAIL glitch_rvalid: got %0d rises exp 0", n_rise - r0); end
    checks++; if (n_ferr != f0 || n_ovr != o0) begin errors++; $display("FAIL glitch_pulses: got ferr %0d ovr %0d exp 0 0", n_ferr - f0, n_ovr - o0); end
    send_frame(8'h3C, 1'b1);
    repeat (20) @(posedge clk);
    #1;
    g = (got_q.size() == 1) ? got_q.pop_front() : 8'hxx;
    checks++; if (g !== 8'h3C) begin errors++; $display("FAIL glitch_next: got %h exp 3c", g); end
    got_q.delete();
  endtask

  task automatic test_frame_err;
    int r0, f0, o0;
    logic [7:0] g;
    rready = 1'b1;
    r0 = n_rise; f0 = n_ferr; o0 = n_ovr;
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(g_bit(8'h5A, i));
    rxd = 1'b0;
    repeat (300) @(posedge clk);
    #1 rxd = 1'b1;
    repeat (50) @(posedge clk);
    #1;
    checks++; if (n_ferr != f0 + 1) begin errors++; $display("FAIL ferr_pulse: got %0d cycles exp 1", n_ferr - f0); end
    checks++; if (n_rise != r0 || got_q.size() != 0) begin errors++; $display("FAIL ferr_rvalid: got %0d rises exp 0", n_rise - r0); end
    checks++; if (n_ovr != o0) begin errors++; $display("FAIL ferr_ovr: got %0d exp 0", n_ovr - o0); end
    send_frame(8'h81, 1'b1);
    repeat (20) @(posedge clk);
    #1;
    g = (got_q.size() == 1) ? got_q.pop_front() : 8'hxx;
    checks++; if (g !== 8'h81) begin errors++; $display("FAIL ferr_next: got %h exp 81", g); end
    got_q.delete();
  endtask

  function automatic logic g_bit(input logic [7:0] b, input int i);
    return b[i];
  endfunction

  task automatic test_overrun;
    int r0, o0;
    logic [7:0] b3, g;
    rready = 1'b0;
    r0 = n_rise; o0 = n_ovr;
    b3 = 8'($urandom_range(0, 255));
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    send_frame(b3, 1'b1);
    repeat (20) @(posedge clk);
    #1;
    checks++; if (rvalid !== 1'b1) begin errors++; $display("FAIL ovr_rvalid: got %b exp 1", rvalid); end
    checks++; if (rdata !== 8'h11) begin errors++; $display("FAIL ovr_rdata: got %h exp 11", rdata); end
    checks++; if (n_ovr != o0 + 2) begin errors++; $display("FAIL ovr_pulses: got %0d exp 2", n_ovr - o0); end
    checks++; if (n_rise != r0 + 1) begin errors++; $display("FAIL ovr_rise: got %0d exp 1", n_rise - r0); end
    rready = 1'b1;
    @(posedge clk);
    #1 rready = 1'b0;
    g = (got_q.size() == 1) ? got_q.pop_front() : 8'hxx;
    checks++; if (g !== 8'h11) begin errors++; $display("FAIL ovr_consume: got %h exp 11", g); end
    checks++; if (rvalid !== 1'b0) begin errors++; $display("FAIL ovr_drop_valid: got %b exp 0", rvalid); end
    checks++; if (rdata !== 8'h11) begin errors++; $display("FAIL ovr_hold_rdata: got %h exp 11", rdata); end
    got_q.delete();
  endtask

  task automatic test_back_to_back;
    int l0, o0;
    logic [7:0] g;
    rready = 1'b0;
    o0 = n_ovr;
    send_frame(8'h33, 1'b1);
    repeat (20) @(posedge clk);
    #1;
    checks++; if (rvalid !== 1'b1 || rdata !== 8'h33) begin errors++; $display("FAIL b2b_first: got %b/%h exp 1/33", rvalid, rdata); end
    l0 = n_low;
    fork
      send_frame(8'h44, 1'b1);
      begin
        repeat (LAT_EVT - 1) @(posedge clk);
        #1 rready = 1'b1;
        @(posedge clk);
        #1 rready = 1'b0;
      end
    join
    repeat (10) @(posedge clk);
    #1;
    checks++; if (n_low != l0) begin errors++; $display("FAIL b2b_valid_gap: got %0d low cycles exp 0", n_low - l0); end
    checks++; if (rdata !== 8'h44) begin errors++; $display("FAIL b2b_rdata: got %h exp 44", rdata); end
    checks++; if (n_ovr != o0) begin errors++; $display("FAIL b2b_ovr: got %0d exp 0", n_ovr - o0); end
    g = (got_q.size() == 1) ? got_q.pop_front() : 8'hxx;
    checks++; if (g !== 8'h33) begin errors++; $display("FAIL b2b_consumed: got %h exp 33", g); end
    rready = 1'b1;
    @(posedge clk);
    #1 rready = 1'b0;
    g = (got_q.size() == 1) ? got_q.pop_front() : 8'hxx;
    checks++; if (g !== 8'h44) begin errors++; $display("FAIL b2b_second: got %h exp 44", g); end
    got_q.delete();
  endtask

  task automatic test_reset_mid;
    int r0, f0, o0;
    logic [7:0] b, g;
    rready = 1'b0;
    send_frame(8'($urandom_range(0, 255)), 1'b1);
    repeat (20) @(posedge clk);
    #1;
    r0 = n_rise; f0 = n_ferr; o0 = n_ovr;
    // Upper nibble high keeps the line idle after release, so no false start.
    b = {4'hF, 4'($urandom_range(0, 15))};
    fork
      send_frame(b, 1'b1);
      begin
        repeat (5 * WC + 40) @(posedge clk);
        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (rvalid !== 1'b0 || rdata !== 8'h00 || frame_err !== 1'b0 || overrun !== 1'b0) begin
          errors++; $display("FAIL midrst_outputs: got %b/%h/%b/%b exp 0/00/0/0", rvalid, rdata, frame_err, overrun);
        end
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
      end
    join
    repeat (100) @(posedge clk);
    #1;
    checks++; if (n_rise != r0 || rvalid !== 1'b0) begin errors++; $display("FAIL midrst_rvalid: got %0d rises exp 0", n_rise - r0); end
    checks++; if (n_ferr != f0 || n_ovr != o0) begin errors++; $display("FAIL midrst_pulses: got ferr %0d ovr %0d exp 0 0", n_ferr - f0, n_ovr - o0); end
    rready = 1'b1;
    send_frame(8'hF0, 1'b1);
    repeat (20) @(posedge clk);
    #1;
    g = (got_q.size() == 1) ? got_q.pop_front() : 8'hxx;
    checks++; if (g !== 8'hF0) begin errors++; $display("FAIL midrst_next: got %h exp f0", g); end
    got_q.delete();
  endtask

  initial begin
    test_reset;
    test_basic;
    test_glitch;
    test_frame_err;
    test_overrun;
    test_back_to_back;
    test_reset_mid;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter CLK_FREQ_MHZ, default 100, meaning the clk_i frequency in MHz.
REQ-002 SHALL have parameter BAUD_RATE, default 921600, meaning the serial bit rate in bits/s.
REQ-003 SHALL have port clk_i, input, 1 bit: the single clock; all logic on its rising edge.
REQ-004 SHALL have port rst_ni, input, 1 bit: reset, asynchronous assert, active-low.
REQ-005 SHALL have port rxd_i, input, 1 bit: serial line, asynchronous to clk_i, idle high.
REQ-006 SHALL have port rvalid_o, output, 1 bit: rdata_o holds an unconsumed byte.
REQ-007 SHALL have port rready_i, input, 1 bit: consumer accepts the byte.
REQ-008 SHALL have port rdata_o, output, 8 bits: received byte, LSB first on the line.
REQ-009 SHALL have port frame_err_o, output, 1 bit: one-cycle pulse when the stop bit is sampled low.
REQ-010 SHALL have port overrun_o, output, 1 bit: one-cycle pulse when a byte is dropped.

Function
REQ-011 SHALL use WAIT_COUNT = (CLK_FREQ_MHZ*1000000)/BAUD_RATE (integer division) clocks per bit and HALF = WAIT_COUNT/2; wait counter width $clog2(WAIT_COUNT).
REQ-012 SHALL pass rxd_i through a 2-flop synchronizer, both flops reset to 1; "rx" below means the synchronizer output.
REQ-013 SHALL implement FSM states IDLE, START, DATA, STOP, BREAK.
REQ-014 IDLE: rx==0 -> START, wait counter loaded with HALF-1.
REQ-015 Wait counter decrements by 1 each cycle outside IDLE; an "event" is wait counter == 0.
REQ-016 START event: rx==0 -> DATA, counter = WAIT_COUNT-1, bit counter = 7; rx==1 -> IDLE (glitch rejected, no outputs change).
REQ-017 DATA event: shift register = {rx, shift[7:1]}, counter = WAIT_COUNT-1; if bit counter == 0 -> STOP, else bit counter decrements.
REQ-018 STOP event with rx==1 -> IDLE and deliver the byte per REQ-020..022.
REQ-019 STOP event with rx==0 -> frame_err_o = 1 for exactly the next cycle, byte discarded, state BREAK; BREAK -> IDLE on the first cycle rx==1.
REQ-020 Delivery when rvalid_o==0, or rvalid_o==1 and rready_i==1 in the same cycle: rdata_o = shift register, rvalid_o = 1 from the next cycle.
REQ-021 Delivery when rvalid_o==1 and rready_i==0: overrun_o = 1 for exactly the next cycle; rdata_o and rvalid_o unchanged (new byte dropped).
REQ-022 rvalid_o==1 and rready_i==1 with no delivery: rvalid_o = 0 next cycle; rdata_o holds its value.
REQ-023 rdata_o SHALL change only on delivery; rready_i while rvalid_o==0 has no effect.
REQ-024 Latency: rvalid_o rises one clock after the STOP-event cycle, i.e. about 9.5 bit times plus 3 clocks after the start-bit falling edge on rxd_i.
REQ-025 Returning to IDLE at mid-stop-bit SHALL allow a start bit that follows the stop bit directly (back-to-back frames).

Reset
REQ-026 While rst_ni==0: state = IDLE, rvalid_o = 0, rdata_o = 8'h00, frame_err_o = 0, overrun_o = 0, synchronizer flops = 1, counters = 0.
REQ-027 Reset mid-frame SHALL abandon the frame; after release the block waits in IDLE for the next falling edge, with no output pulses.

Verification (CLK_FREQ_MHZ=100, BAUD_RATE=921600: WAIT_COUNT=108, HALF=54)
REQ-028 Frame 0xA5 at 108 clocks/bit with rready_i=1 -> one rvalid_o pulse, rdata_o=8'hA5, no error pulses.
REQ-029 rxd_i low for 20 clocks, then high -> no rvalid_o, state back to IDLE; a following 0x3C frame is received correctly.
REQ-030 Frame 0x5A with the stop bit driven low, held low for 300 clocks, then high -> one frame_err_o pulse, no rvalid_o; the next frame 0x81 is received as 8'h81.
REQ-031 Frames 0x11 then 0x22 back to back with rready_i=0 -> rdata_o=8'h11, rvalid_o=1, one overrun_o pulse at the second stop sample.
REQ-032 rready_i=1 exactly in the delivery cycle of a second frame (0x33 then 0x44) -> rvalid_o stays 1, rdata_o=8'h44, no overrun_o.
REQ-033 rst_ni pulsed low during bit 4 of a frame -> all outputs 0 and no pulses; a clean 0xF0 frame afterwards yields 8'hF0.
